// File: rtl/bus_wait_ctrl.sv
// Chip-select decoder and wait-state generator for the latched 8086 system bus.
// Drives CPU ready with per-region wait states and flags unmapped/illegal cycles.
module bus_wait_ctrl #(
   parameter int unsigned ROM_WAIT = 2,
   parameter int unsigned RAM_WAIT = 0,
   parameter int unsigned IO_WAIT  = 3,
   parameter logic [19:0] ROM_BASE = 20'hF8000,
   parameter logic [19:0] RAM_TOP  = 20'h7FFFF,
   parameter logic [15:0] IO_TOP   = 16'h00FF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m_ioN,
   input  logic        rdN,
   input  logic        wrN,
   input  logic        bheN,
   input  logic [19:0] addr,
   output logic        ready,
   output logic        rom_csN,
   output logic        ram_csN,
   output logic        io_csN,
   output logic        ble_N,
   output logic        bhe_N,
   output logic        bus_err
);

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACTIVE,
      S_RECOVER
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ready_q, ready_d;
   logic               rom_cs_q, rom_cs_d;
   logic               ram_cs_q, ram_cs_d;
   logic               io_cs_q, io_cs_d;
   logic               ble_q, ble_d;
   logic               bhe_q, bhe_d;
   logic               err_q, err_d;

   logic               strb;
   logic               illegal;
   logic               rom_hit, ram_hit, io_hit, mapped;
   logic [CNT_W-1:0]   wait_sel;

   // Command and region decode, only consumed when a cycle starts in IDLE
   always_comb begin
      strb     = ~rdN | ~wrN;
      illegal  = ~rdN & ~wrN;
      rom_hit  = m_ioN & (addr >= ROM_BASE);
      ram_hit  = m_ioN & ~rom_hit & (addr <= RAM_TOP);
      io_hit   = ~m_ioN & (addr[15:0] <= IO_TOP);
      mapped   = rom_hit | ram_hit | io_hit;
      if (rom_hit) begin
         wait_sel = CNT_W'(ROM_WAIT);
      end else if (ram_hit) begin
         wait_sel = CNT_W'(RAM_WAIT);
      end else begin
         wait_sel = CNT_W'(IO_WAIT);
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ready_d  = ready_q;
      rom_cs_d = rom_cs_q;
      ram_cs_d = ram_cs_q;
      io_cs_d  = io_cs_q;
      ble_d    = ble_q;
      bhe_d    = bhe_q;
      err_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (strb) begin
               if (illegal || !mapped) begin
                  err_d   = 1'b1;
                  state_d = S_RECOVER;
               end else begin
                  rom_cs_d = ~rom_hit;
                  ram_cs_d = ~ram_hit;
                  io_cs_d  = ~io_hit;
                  ble_d    = addr[0];
                  bhe_d    = bheN;
                  if (wait_sel != '0) begin
                     ready_d = 1'b0;
                     cnt_d   = wait_sel - CNT_W'(1);
                     state_d = S_WAIT;
                  end else begin
                     state_d = S_ACTIVE;
                  end
               end
            end
         end

         S_WAIT: begin
            if (illegal || !strb) begin
               ready_d  = 1'b1;
               rom_cs_d = 1'b1;
               ram_cs_d = 1'b1;
               io_cs_d  = 1'b1;
               ble_d    = 1'b1;
               bhe_d    = 1'b1;
               cnt_d    = '0;
               err_d    = illegal;
               state_d  = illegal ? S_RECOVER : S_IDLE;
            end else if (cnt_q == '0) begin
               ready_d = 1'b1;
               state_d = S_ACTIVE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         S_ACTIVE: begin
            if (illegal || !strb) begin
               rom_cs_d = 1'b1;
               ram_cs_d = 1'b1;
               io_cs_d  = 1'b1;
               ble_d    = 1'b1;
               bhe_d    = 1'b1;
               err_d    = illegal;
               state_d  = illegal ? S_RECOVER : S_IDLE;
            end
         end

         S_RECOVER: begin
            // Hold off re-decoding until the offending strobe is released
            if (!strb) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         ready_q  <= 1'b1;
         rom_cs_q <= 1'b1;
         ram_cs_q <= 1'b1;
         io_cs_q  <= 1'b1;
         ble_q    <= 1'b1;
         bhe_q    <= 1'b1;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ready_q  <= ready_d;
         rom_cs_q <= rom_cs_d;
         ram_cs_q <= ram_cs_d;
         io_cs_q  <= io_cs_d;
         ble_q    <= ble_d;
         bhe_q    <= bhe_d;
         err_q    <= err_d;
      end
   end

   assign ready   = ready_q;
   assign rom_csN = rom_cs_q;
   assign ram_csN = ram_cs_q;
   assign io_csN  = io_cs_q;
   assign ble_N   = ble_q;
   assign bhe_N   = bhe_q;
   assign bus_err = err_q;

endmodule

// File: tb/tb_bus_wait_ctrl.sv
// Directed bench for bus_wait_ctrl; outputs checked as the vector
// {ready, rom_csN, ram_csN, io_csN, ble_N, bhe_N, bus_err}.
module tb_bus_wait_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        m_ioN;
   logic        rdN;
   logic        wrN;
   logic        bheN;
   logic [19:0] addr;
   logic        ready;
   logic        rom_csN;
   logic        ram_csN;
   logic        io_csN;
   logic        ble_N;
   logic        bhe_N;
   logic        bus_err;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [6:0] IDLE_V   = 7'b1111110;
   localparam logic [6:0] ERR_V    = 7'b1111111;
   localparam logic [6:0] ROM_WT_V = 7'b0011010;
   localparam logic [6:0] ROM_AC_V = 7'b1011010;
   localparam logic [6:0] RAM_W0_V = 7'b1101000;
   localparam logic [6:0] RAM_RD_V = 7'b1101010;
   localparam logic [6:0] RAM_B1_V = 7'b1101110;
   localparam logic [6:0] IO_WT_V  = 7'b0110010;
   localparam logic [6:0] IO_AC_V  = 7'b1110010;

   bus_wait_ctrl dut (
      .clk     (clk),
      .reset   (reset),
      .m_ioN   (m_ioN),
      .rdN     (rdN),
      .wrN     (wrN),
      .bheN    (bheN),
      .addr    (addr),
      .ready   (ready),
      .rom_csN (rom_csN),
      .ram_csN (ram_csN),
      .io_csN  (io_csN),
      .ble_N   (ble_N),
      .bhe_N   (bhe_N),
      .bus_err (bus_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [6:0] exp);
      logic [6:0] obs;
      obs = {ready, rom_csN, ram_csN, io_csN, ble_N, bhe_N, bus_err};
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %b required %b", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1;
      m_ioN = 1'b1;
      rdN   = 1'b1;
      wrN   = 1'b1;
      bheN  = 1'b1;
      addr  = 20'h00000;
      tick();
      tick();
      chk("reset_values", IDLE_V);
      reset = 1'b0;
      tick();
      chk("idle_after_reset", IDLE_V);

      // ROM read, 2 waits; address moved mid-cycle must not move CS or lanes
      addr = 20'hFFFF0;
      rdN  = 1'b0;
      tick();
      chk("rom_wait1", ROM_WT_V);
      addr = 20'h00001;
      tick();
      chk("rom_wait2", ROM_WT_V);
      tick();
      chk("rom_ready", ROM_AC_V);
      tick();
      tick();
      tick();
      chk("rom_held", ROM_AC_V);
      rdN = 1'b1;
      tick();
      chk("rom_release", IDLE_V);

      // RAM word write, zero waits
      addr = 20'h01234;
      bheN = 1'b0;
      wrN  = 1'b0;
      tick();
      chk("ram_wr_c1", RAM_W0_V);
      tick();
      tick();
      chk("ram_wr_c3", RAM_W0_V);
      wrN = 1'b1;
      tick();
      chk("ram_wr_release", IDLE_V);
      bheN = 1'b1;

      // I/O read at port 0x0040, 3 waits
      m_ioN = 1'b0;
      addr  = 20'h00040;
      rdN   = 1'b0;
      tick();
      chk("io_wait1", IO_WT_V);
      tick();
      chk("io_wait2", IO_WT_V);
      tick();
      chk("io_wait3", IO_WT_V);
      tick();
      chk("io_ready", IO_AC_V);
      rdN = 1'b1;
      tick();
      chk("io_release", IDLE_V);

      // I/O port 0x0100 is unmapped
      addr = 20'h00100;
      rdN  = 1'b0;
      tick();
      chk("io_unmapped_err", ERR_V);
      tick();
      chk("io_unmapped_once", IDLE_V);
      rdN = 1'b1;
      tick();
      chk("io_unmapped_idle", IDLE_V);
      m_ioN = 1'b1;

      // Unmapped memory: single error pulse, stuck strobe must not retrigger
      addr = 20'h90000;
      rdN  = 1'b0;
      tick();
      chk("mem_unmapped_err", ERR_V);
      tick();
      chk("recover_1", IDLE_V);
      tick();
      tick();
      chk("recover_3", IDLE_V);
      rdN = 1'b1;
      tick();
      chk("recover_exit", IDLE_V);
      addr = 20'h00010;
      rdN  = 1'b0;
      tick();
      chk("post_recover_ram", RAM_RD_V);
      rdN = 1'b1;
      tick();
      chk("post_recover_idle", IDLE_V);

      // Abort during ROM wait
      addr = 20'hFFFF0;
      rdN  = 1'b0;
      tick();
      chk("abort_wait", ROM_WT_V);
      rdN = 1'b1;
      tick();
      chk("abort_release", IDLE_V);
      tick();
      chk("abort_no_err", IDLE_V);

      // Illegal at cycle start
      addr = 20'h00010;
      rdN  = 1'b0;
      wrN  = 1'b0;
      tick();
      chk("illegal_start", ERR_V);
      rdN = 1'b1;
      wrN = 1'b1;
      tick();
      chk("illegal_start_end", IDLE_V);

      // Illegal mid-cycle while waiting
      addr = 20'hFFFF0;
      rdN  = 1'b0;
      tick();
      chk("illegal_mid_wait", ROM_WT_V);
      wrN = 1'b0;
      tick();
      chk("illegal_mid_err", ERR_V);
      rdN = 1'b1;
      wrN = 1'b1;
      tick();
      chk("illegal_mid_end", IDLE_V);

      // Illegal mid-cycle while active (RAM, zero waits)
      addr = 20'h00010;
      rdN  = 1'b0;
      tick();
      chk("illegal_act_ram", RAM_RD_V);
      wrN = 1'b0;
      tick();
      chk("illegal_act_err", ERR_V);
      rdN = 1'b1;
      wrN = 1'b1;
      tick();
      chk("illegal_act_end", IDLE_V);

      // Reset during the second I/O wait cycle
      m_ioN = 1'b0;
      addr  = 20'h00040;
      rdN   = 1'b0;
      tick();
      chk("rst_io_wait1", IO_WT_V);
      tick();
      chk("rst_io_wait2", IO_WT_V);
      reset = 1'b1;
      tick();
      chk("rst_mid_wait", IDLE_V);
      reset = 1'b0;
      rdN   = 1'b1;
      tick();
      chk("rst_idle", IDLE_V);

      // Fresh odd-byte RAM write after reset
      m_ioN = 1'b1;
      addr  = 20'h01235;
      wrN   = 1'b0;
      tick();
      chk("post_rst_ram", RAM_B1_V);
      wrN = 1'b1;
      tick();
      chk("post_rst_idle", IDLE_V);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bus_wait_ctrl.md
Name: bus_wait_ctrl

Overview:
Downstream consumer of the latched/buffered 8086 system bus. Decodes the demultiplexed address and command strobes into registered chip selects for ROM, RAM and I/O. Generates the CPU `ready` line with a per-region programmable number of wait states, and flags illegal or unmapped cycles. Sits between the latched CPU bus and the memory/peripheral devices; its `ready` output feeds back to the CPU `ready` input.

Parameters:
ROM_WAIT, 2, wait states inserted for ROM accesses (0..15)
RAM_WAIT, 0, wait states inserted for RAM accesses (0..15)
IO_WAIT, 3, wait states inserted for I/O accesses (0..15)
ROM_BASE, 20'hF8000, first ROM address; ROM spans ROM_BASE..20'hFFFFF
RAM_TOP, 20'h7FFFF, last RAM address; RAM spans 0..RAM_TOP
IO_TOP, 16'h00FF, last decoded I/O port; I/O spans 0..IO_TOP

Ports:
clk  input  1  system clock, shared with CPU
reset  input  1  synchronous, active-high reset
m_ioN  input  1  1 = memory cycle, 0 = I/O cycle (latched bus)
rdN  input  1  read strobe, active low
wrN  input  1  write strobe, active low
bheN  input  1  latched bus-high-enable, active low
addr  input  20  latched address, {a19to16, a15to8, a7to1, a0}
ready  output  1  to CPU ready; 0 inserts wait states
rom_csN  output  1  ROM chip select, active low
ram_csN  output  1  RAM chip select, active low
io_csN  output  1  I/O chip select, active low
ble_N  output  1  low-byte lane enable (= addr[0] while any CS is active, else 1)
bhe_N  output  1  high-byte lane enable (= bheN while any CS is active, else 1)
bus_err  output  1  one-cycle pulse on an unmapped or illegal cycle

Behaviour:
- Clocking and reset:
  - All outputs are registered.
  - Reset is sampled on the rising edge of `clk`.
  - Reset values: `ready`=1, all `*_csN`=1, `ble_N`=1, `bhe_N`=1, `bus_err`=0, state=IDLE, counter=0.
- Command decode: `strb = ~rdN | ~wrN`.
  - `illegal` = rdN==0 && wrN==0.
- Region decode (combinational, used at cycle start only):
  - Memory cycle (m_ioN=1): addr>=ROM_BASE selects ROM; addr<=RAM_TOP selects RAM; otherwise unmapped.
  - I/O cycle (m_ioN=0): addr[15:0]<=IO_TOP selects IO; otherwise unmapped.
  - ROM takes priority if the ranges overlap.
- States: IDLE, WAIT, ACTIVE, RECOVER.
- IDLE: on the first clock with strb=1, capture the region.
  - Legal and mapped: assert the matching CS next cycle.
    - If that region's wait count N>0: `ready`=0, load counter=N-1, go to WAIT.
    - If N=0: `ready` stays 1, go to ACTIVE.
  - Unmapped or illegal: no CS, `ready` stays 1, `bus_err`=1 for exactly one cycle, go to RECOVER.
- WAIT: `ready` is held 0.
  - Counter decrements each cycle.
  - When the counter equals 0, next cycle `ready`=1 and state goes to ACTIVE.
  - Net effect: `ready` is low for exactly N consecutive cycles, starting the cycle after strb is first sampled.
- ACTIVE: CS and lane enables are held.
  - When strb is sampled 0: all CS=1, lanes=1, go to IDLE.
- RECOVER: wait until strb is sampled 0, then go to IDLE.
  - Blocks re-triggering from the same stuck strobe.
- Abort: strb sampled 0 while in WAIT forces IDLE next cycle with `ready`=1 and CS released; no `bus_err`.
- Illegal mid-cycle: rdN and wrN both 0 while in WAIT or ACTIVE:
  - CS released, `bus_err` pulses once, go to RECOVER.
- Latching of address and region:
  - Address and m_ioN are sampled only at the IDLE→WAIT/ACTIVE transition.
  - Later address changes during the cycle do not move the CS.
- Reset asserted in any state: next cycle all outputs take their reset values, regardless of strb.
- Back-to-back cycles: strb deassert followed by reassert one cycle later starts a fresh decode from IDLE; at least one idle clock is guaranteed by the ACTIVE→IDLE transition.
- Counter is 4 bits wide; parameters are assumed to lie in 0..15.

Test Plan:
- ROM read at addr=20'hFFFF0, m_ioN=1, rdN=0 held 6 cycles with ROM_WAIT=2:
  - rom_csN=0 from cycle+1.
  - ready=0 on cycles +1 and +2, ready=1 from cycle +3.
  - rom_csN=1 the cycle after rdN returns to 1.
- RAM word write at addr=20'h01234, bheN=0, wrN=0, RAM_WAIT=0:
  - ready never drops.
  - ram_csN=0, ble_N=0, bhe_N=0 from cycle+1 until one cycle after wrN rises.
- I/O read at port 16'h0040, m_ioN=0, IO_WAIT=3:
  - io_csN=0, ready low for exactly 3 cycles.
  - Also port 16'h0100: bus_err pulses once, no CS, ready=1.
- Unmapped memory read at 20'h90000:
  - bus_err=1 for one cycle, all CS=1, ready=1.
  - FSM stays in RECOVER until rdN=1, then accepts the next cycle normally.
- Abort and illegal:
  - rdN released during WAIT (ROM, 2 waits, rdN low 1 cycle) → ready=1 and rom_csN=1 next cycle, bus_err=0.
  - rdN=0 and wrN=0 together → bus_err pulse, no CS.
- Reset mid-WAIT:
  - Assert reset during the second I/O wait cycle → next cycle ready=1, io_csN=1, state IDLE.
  - After reset, a new cycle decodes normally.
